qdi_chan_bridge_fifo: RTL and testbench
=======================================

Name: qdi_chan_bridge_fifo

Overview:
Clocked bridge between two asynchronous 4-phase QDI channels, parametrised in width and buffer depth. Sink side accepts dual-rail (1-of-2 per bit) tokens with an active-high enable and pushes them into a FIFO. Source side pops the FIFO and re-emits tokens on a dual-rail output channel. Sits on the Verilog side of prsim co-simulation benches as a parametrised replacement for fixed delay-element chains. Adds buffering, flow control, release gating, token counters and illegal-code detection.

Parameters:
WIDTH, 2, logical bits per token; each bit is carried on 2 rails.
DEPTH, 4, FIFO entries; must be ≥1.
SYNC_STAGES, 2, flip-flop synchroniser depth on every asynchronous input rail; must be ≥1.
CNT_W, 16, width of the token counters.

Ports:
clk  input  1  sole clock; rising-edge.
rst_n  input  1  synchronous reset, active-low.
release  input  1  0 holds both channels in their reset state (equivalent of channel-release); 1 runs.
in_d  input  2*WIDTH  sink data rails; bit i uses rails [2i] (false) and [2i+1] (true).
in_e  output  1  sink enable / acknowledge; active-high.
out_d  output  2*WIDTH  source data rails, same encoding as in_d.
out_e  input  1  source-side enable from the consumer; active-high.
tok_in_cnt  output  CNT_W  tokens accepted; wraps modulo 2^CNT_W.
tok_out_cnt  output  CNT_W  tokens completed on the source side; wraps.
level  output  $clog2(DEPTH+1)  current FIFO occupancy.
err  output  1  sticky illegal-code flag.

Behaviour:
- Reset (rst_n=0 at a clk edge): in_e=0, out_d=0, FIFO empty, level=0, both counters 0, err=0. Both FSMs go to RST. This applies mid-handshake and abandons any partial token.
- All in_d rails and out_e pass through SYNC_STAGES flops before use. All outputs are registered.
- Bit i is valid when exactly one of its rails is 1 and neutral when both are 0. The whole word is valid when all bits are valid and neutral when all rails are 0.
- Sink FSM states: RST, WAIT_VALID, WAIT_NEUTRAL.
  - RST: in_e=0. Go to WAIT_VALID with in_e=1 at the first edge where release=1.
  - WAIT_VALID:
    - If the synchronised word is valid and the FIFO is not full, push the decoded WIDTH-bit value, increment tok_in_cnt, set in_e=0 and go to WAIT_NEUTRAL.
    - If the FIFO is full, stall with in_e=1 and do not capture.
  - WAIT_NEUTRAL: when the synchronised word is neutral, set in_e=1 and go to WAIT_VALID.
- Source FSM states: RST, IDLE, WAIT_ACK, WAIT_RESET.
  - RST: out_d=0. Go to IDLE when release=1.
  - IDLE: if the FIFO is not empty and synchronised out_e=1, drive out_d with the head encoding (rail [2i+1]=bit, [2i]=~bit), pop the FIFO and go to WAIT_ACK.
  - WAIT_ACK: when synchronised out_e=0, set out_d=0, increment tok_out_cnt and go to WAIT_RESET.
  - WAIT_RESET: when synchronised out_e=1, go to IDLE.
- release falling to 0 mid-operation:
  - Each FSM finishes its current handshake, then parks in RST.
  - FIFO contents and counters are retained.
- Latency:
  - A valid in_d stable at edge 0 produces in_e falling at edge SYNC_STAGES+1.
  - With out_e already high and the FIFO previously empty, out_d is driven at edge SYNC_STAGES+2. There is no same-cycle bypass through the FIFO.
- FIFO boundaries:
  - Push uses the registered full flag; pop uses the registered empty flag.
  - A simultaneous push and pop leaves level unchanged.
  - If the FIFO is full at an edge, no push occurs that edge even if a pop happens.
  - Read and write pointers wrap modulo DEPTH.
- Illegal code:
  - Any synchronised bit with both rails 1 while the sink is in WAIT_VALID sets err=1.
  - The token is not captured; the sink stays in WAIT_VALID until the word becomes neutral again.
  - err clears only on reset.
- Counter wrap: 2^CNT_W−1 + 1 → 0, with no flag.

Test Plan:
1. Reset/release:
   - Stimulus: rst_n=0 for 3 cycles, release=0.
   - Required: in_e=0, out_d=0, level=0, err=0.
   - Then release=1; required: in_e=1 within 1 cycle.
2. Single token, WIDTH=2, value 2'b10:
   - Stimulus: in_d=4'b1001, out_e=1.
   - Required: in_e=0 at edge 3, out_d=4'b1001 at edge 4.
   - Then out_e→0; required: out_d=0 and tok_out_cnt=1.
3. Backpressure, DEPTH=4:
   - Stimulus: out_e held 0, 5 tokens offered.
   - Required: 4 accepted (level=4, tok_in_cnt=4), and in_e stays 1 on the 5th.
   - Then release out_e; required: the 5th token is accepted after the first pop, and output order is 0,1,2,3,4.
4. Illegal code: in_d=4'b0011 → err=1, level unchanged, no in_e falling edge. Then neutral, then legal 4'b0101 → accepted normally.
5. Reset mid-handshake: assert rst_n=0 while the source is in WAIT_ACK with 2 tokens queued → next cycle out_d=0, level=0, counters=0.
6. Counter wrap, CNT_W=3: pass 9 tokens → tok_in_cnt=1, tok_out_cnt=1.

Source files
------------

// File: rtl/qdi_chan_bridge_fifo_if.sv
// Dual-rail QDI channel pair seen by the bridge: a sink channel (in_d/in_e)
// and a source channel (out_d/out_e).
//
// Handshake: both channels are 4-phase return-to-zero. Data rails carry one
// rail-pair per bit (rail 2i = false, rail 2i+1 = true). The producer raises
// exactly one rail per bit only while the consumer's enable is high. The
// consumer then drops its enable. The producer returns all rails to zero.
// The consumer re-raises its enable. A token is transferred exactly once per
// enable falling edge.
interface qdi_chan_bridge_fifo_if #(
  parameter int WIDTH = 2
);
  logic [2*WIDTH-1:0] in_d;
  logic               in_e;
  logic [2*WIDTH-1:0] out_d;
  logic               out_e;

  // Bridge side
  modport slave (
    input  in_d,
    output in_e,
    output out_d,
    input  out_e
  );

  // Environment side (token producer feeding in_d, consumer driving out_e)
  modport master (
    output in_d,
    input  in_e,
    input  out_d,
    output out_e
  );
endinterface

// File: rtl/qdi_chan_bridge_fifo.sv
// Clocked bridge between two 4-phase dual-rail QDI channels. Sink tokens are
// decoded into a FIFO and re-emitted dual-rail on the source channel, with
// release gating, token counters and a sticky illegal-code flag.
module qdi_chan_bridge_fifo #(
  parameter int WIDTH       = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   chan_release,
  qdi_chan_bridge_fifo_if.slave  ch,
  output logic [CNT_W-1:0]       tok_in_cnt,
  output logic [CNT_W-1:0]       tok_out_cnt,
  output logic [LVL_W-1:0]       level,
  output logic                   err,
  output logic [1:0]             sink_state,
  output logic [1:0]             src_state
);

  localparam int RW = 2 * WIDTH;
  localparam int SW = RW + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    SK_RST          = 2'd0,
    SK_WAIT_VALID   = 2'd1,
    SK_WAIT_NEUTRAL = 2'd2
  } sink_st_t;

  typedef enum logic [1:0] {
    SR_RST        = 2'd0,
    SR_IDLE       = 2'd1,
    SR_WAIT_ACK   = 2'd2,
    SR_WAIT_RESET = 2'd3
  } src_st_t;

  // Synchroniser chain: {out_e, in_d} travel together through every stage
  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] sync_d [SYNC_STAGES];

  sink_st_t sink_q, sink_d;
  src_st_t  src_q, src_d;
  logic     in_e_q, in_e_d;
  logic [RW-1:0] out_d_q, out_d_d;
  logic     blk_q, blk_d;
  logic     err_q, err_d;
  logic [CNT_W-1:0] tok_in_q, tok_in_d;
  logic [CNT_W-1:0] tok_out_q, tok_out_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  logic [RW-1:0]    in_s;
  logic             oe_s;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] head;
  logic             word_valid;
  logic             word_bad;
  logic             word_neutral;
  logic             push;
  logic             pop;

  assign in_s         = sync_q[SYNC_STAGES-1][RW-1:0];
  assign oe_s         = sync_q[SYNC_STAGES-1][RW];
  assign word_neutral = (in_s == '0);
  assign head         = mem_q[rd_ptr_q];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Shift asynchronous rails one stage per clock
  always_comb begin
    sync_d[0] = {ch.out_e, ch.in_d};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Dual-rail decode of the synchronised sink word
  always_comb begin
    word_valid = 1'b1;
    word_bad   = 1'b0;
    dec_val    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec_val[i] = in_s[2*i+1];
      if (in_s[2*i] == in_s[2*i+1]) word_valid = 1'b0;
      if (in_s[2*i] && in_s[2*i+1]) word_bad = 1'b1;
    end
  end

  // Sink FSM: capture a valid word into the FIFO, then wait for return-to-zero
  always_comb begin
    sink_d   = sink_q;
    in_e_d   = in_e_q;
    blk_d    = blk_q;
    err_d    = err_q;
    tok_in_d = tok_in_q;
    push     = 1'b0;
    case (sink_q)
      SK_RST: begin
        in_e_d = 1'b0;
        if (chan_release) begin
          sink_d = SK_WAIT_VALID;
          in_e_d = 1'b1;
        end
      end
      SK_WAIT_VALID: begin
        // An illegal word blocks capture until the rails have been neutral
        if (word_bad) begin
          err_d = 1'b1;
          blk_d = 1'b1;
        end else if (word_neutral) begin
          blk_d = 1'b0;
        end
        // Enable is already offered, so a valid word is taken even if
        // release has just dropped; otherwise park.
        if (word_valid && !blk_q && !full_q) begin
          push     = 1'b1;
          tok_in_d = tok_in_q + CNT_W'(1);
          in_e_d   = 1'b0;
          sink_d   = SK_WAIT_NEUTRAL;
        end else if (!chan_release) begin
          in_e_d = 1'b0;
          sink_d = SK_RST;
        end
      end
      SK_WAIT_NEUTRAL: begin
        if (word_neutral) begin
          if (chan_release) begin
            in_e_d = 1'b1;
            sink_d = SK_WAIT_VALID;
          end else begin
            in_e_d = 1'b0;
            sink_d = SK_RST;
          end
        end
      end
      default: begin
        in_e_d = 1'b0;
        sink_d = SK_RST;
      end
    endcase
  end

  // Source FSM: pop the head, present it dual-rail, then return to zero
  always_comb begin
    src_d     = src_q;
    out_d_d   = out_d_q;
    tok_out_d = tok_out_q;
    pop       = 1'b0;
    case (src_q)
      SR_RST: begin
        out_d_d = '0;
        if (chan_release) src_d = SR_IDLE;
      end
      SR_IDLE: begin
        if (!chan_release) begin
          src_d = SR_RST;
        end else if (!empty_q && oe_s) begin
          for (int i = 0; i < WIDTH; i++) begin
            out_d_d[2*i+1] = head[i];
            out_d_d[2*i]   = ~head[i];
          end
          pop   = 1'b1;
          src_d = SR_WAIT_ACK;
        end
      end
      SR_WAIT_ACK: begin
        if (!oe_s) begin
          out_d_d   = '0;
          tok_out_d = tok_out_q + CNT_W'(1);
          src_d     = SR_WAIT_RESET;
        end
      end
      SR_WAIT_RESET: begin
        if (oe_s) src_d = chan_release ? SR_IDLE : SR_RST;
      end
      default: begin
        out_d_d = '0;
        src_d   = SR_RST;
      end
    endcase
  end

  // FIFO storage, pointers and registered full/empty flags
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    if (push) begin
      mem_d[wr_ptr_q] = dec_val;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      lvl_d = lvl_q + LVL_W'(1);
    end else if (pop && !push) begin
      lvl_d = lvl_q - LVL_W'(1);
    end
    full_d  = (lvl_d == LVL_W'(DEPTH));
    empty_d = (lvl_d == '0);
  end

  // State register for all flops, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sink_q    <= SK_RST;
      src_q     <= SR_RST;
      in_e_q    <= 1'b0;
      out_d_q   <= '0;
      blk_q     <= 1'b0;
      err_q     <= 1'b0;
      tok_in_q  <= '0;
      tok_out_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      lvl_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      mem_q     <= mem_d;
      sink_q    <= sink_d;
      src_q     <= src_d;
      in_e_q    <= in_e_d;
      out_d_q   <= out_d_d;
      blk_q     <= blk_d;
      err_q     <= err_d;
      tok_in_q  <= tok_in_d;
      tok_out_q <= tok_out_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      lvl_q     <= lvl_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  assign ch.in_e     = in_e_q;
  assign ch.out_d    = out_d_q;
  assign tok_in_cnt  = tok_in_q;
  assign tok_out_cnt = tok_out_q;
  assign level       = lvl_q;
  assign err         = err_q;
  assign sink_state  = sink_q;
  assign src_state   = src_q;

endmodule

// File: tb/tb_qdi_chan_bridge_fifo.sv
// Self-checking bench for qdi_chan_bridge_fifo: WIDTH=2, DEPTH=4,
// SYNC_STAGES=2, CNT_W=3 so the counter wrap is reachable quickly.
module tb_qdi_chan_bridge_fifo;
  localparam int W  = 2;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rel = 1'b0;
  logic [CW-1:0] tok_in_cnt;
  logic [CW-1:0] tok_out_cnt;
  logic [LW-1:0] level;
  logic          err;
  logic [1:0]    sink_state;
  logic [1:0]    src_state;

  int n_chk = 0;
  int n_bad = 0;
  int n_in  = 0;
  int n_out = 0;
  logic [W-1:0] exp_q[$];

  qdi_chan_bridge_fifo_if #(.WIDTH(W)) ifc ();

  qdi_chan_bridge_fifo #(
    .WIDTH(W), .DEPTH(D), .SYNC_STAGES(2), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .chan_release (rel),
    .ch           (ifc),
    .tok_in_cnt   (tok_in_cnt),
    .tok_out_cnt  (tok_out_cnt),
    .level        (level),
    .err          (err),
    .sink_state   (sink_state),
    .src_state    (src_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] dec(input logic [2*W-1:0] r);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = r[2*i+1];
    return v;
  endfunction

  function automatic logic word_ok(input logic [2*W-1:0] r);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < W; i++) if (r[2*i] == r[2*i+1]) ok = 1'b0;
    return ok;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_in_e(input logic v, input int limit, input string tag);
    int n;
    n = 0;
    while (ifc.in_e !== v && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(ifc.in_e), 32'(v));
  endtask

  // Sink driver: one full 4-phase token
  task automatic send_tok(input logic [W-1:0] v, input string tag);
    wait_in_e(1'b1, 300, {tag, "_rdy"});
    ifc.in_d = enc(v);
    exp_q.push_back(v);
    wait_in_e(1'b0, 300, {tag, "_ack"});
    if (ifc.in_e === 1'b0) n_in++;
    chk({tag, "_incnt"}, 32'(tok_in_cnt), 32'(n_in % 8));
    ifc.in_d = '0;
  endtask

  // Source consumer: take one token, compare with the scoreboard
  task automatic recv_tok(input string tag);
    int n;
    logic [W-1:0] e;
    ifc.out_e = 1'b1;
    n = 0;
    while (!word_ok(ifc.out_d) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, 32'(word_ok(ifc.out_d)), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(dec(ifc.out_d)), 32'(e));
    end else begin
      chk({tag, "_expq"}, 32'(exp_q.size()), 32'd1);
    end
    ifc.out_e = 1'b0;
    n = 0;
    while (ifc.out_d !== '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rtz"}, 32'(ifc.out_d), 32'd0);
    n_out++;
    chk({tag, "_outcnt"}, 32'(tok_out_cnt), 32'(n_out % 8));
    ifc.out_e = 1'b1;
  endtask

  initial begin
    logic [W-1:0] e;
    logic [LW-1:0] lvl0;
    int n;
    int drops;

    ifc.in_d  = '0;
    ifc.out_e = 1'b0;

    // 1. reset and release
    repeat (3) @(negedge clk);
    chk("t1_in_e", 32'(ifc.in_e), 32'd0);
    chk("t1_out_d", 32'(ifc.out_d), 32'd0);
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_cnts", 32'({tok_in_cnt, tok_out_cnt}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_held", 32'(ifc.in_e), 32'd0);
    ifc.out_e = 1'b1;
    rel = 1'b1;
    @(posedge clk);
    #1;
    chk("t1_rel_in_e", 32'(ifc.in_e), 32'd1);
    repeat (4) @(negedge clk);

    // 2. single token 2'b10, edge-exact latency
    ifc.in_d = 4'b1001;
    exp_q.push_back(2'b10);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_in_e_e2", 32'(ifc.in_e), 32'd1);
    @(posedge clk);
    #1;
    chk("t2_in_e_e3", 32'(ifc.in_e), 32'd0);
    n_in++;
    chk("t2_incnt", 32'(tok_in_cnt), 32'(n_in % 8));
    chk("t2_out_d_e3", 32'(ifc.out_d), 32'd0);
    @(posedge clk);
    #1;
    chk("t2_out_d_e4", 32'(ifc.out_d), 32'b1001);
    e = exp_q.pop_front();
    chk("t2_data", 32'(dec(ifc.out_d)), 32'(e));
    ifc.in_d  = '0;
    ifc.out_e = 1'b0;
    n = 0;
    while (ifc.out_d !== '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t2_rtz", 32'(ifc.out_d), 32'd0);
    n_out++;
    chk("t2_outcnt", 32'(tok_out_cnt), 32'd1);

    // 3. backpressure: 5 tokens into a 4-deep FIFO
    repeat (4) @(negedge clk);
    fork
      begin
        for (int k = 0; k < 5; k++) send_tok(W'(k), "t3_tx");
      end
    join_none
    n = 0;
    while (level !== LW'(4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk("t3_level", 32'(level), 32'd4);
    chk("t3_incnt", 32'(tok_in_cnt), 32'(n_in % 8));
    chk("t3_stall_in_e", 32'(ifc.in_e), 32'd1);
    chk("t3_sink_wv", 32'(sink_state), 32'd1);
    for (int k = 0; k < 5; k++) recv_tok("t3_rx");
    wait fork;
    repeat (4) @(negedge clk);
    chk("t3_level_end", 32'(level), 32'd0);

    // 4. illegal code
    lvl0 = level;
    ifc.in_d = 4'b0011;
    drops = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ifc.in_e === 1'b0) drops++;
    end
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_level", 32'(level), 32'(lvl0));
    chk("t4_no_ack", 32'(drops), 32'd0);
    ifc.in_d = '0;
    repeat (4) @(negedge clk);
    send_tok(2'b00, "t4_ok");
    recv_tok("t4_rx");
    chk("t4_err_sticky", 32'(err), 32'd1);

    // 5. reset while the source sits in WAIT_ACK with 2 tokens queued
    ifc.out_e = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) send_tok(W'($urandom_range(0, 3)), "t5_tx");
    ifc.out_e = 1'b1;
    n = 0;
    while (!word_ok(ifc.out_d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_src_ack", 32'(src_state), 32'd2);
    chk("t5_level_pre", 32'(level), 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_out_d", 32'(ifc.out_d), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_cnts", 32'({tok_in_cnt, tok_out_cnt}), 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_in_e", 32'(ifc.in_e), 32'd0);
    exp_q.delete();
    n_in  = 0;
    n_out = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 6. counter wrap: 9 tokens through a 3-bit counter
    fork
      begin
        for (int k = 0; k < 9; k++) begin
          send_tok(W'($urandom_range(0, 3)), "t6_tx");
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 9; k++) recv_tok("t6_rx");
      end
    join
    repeat (4) @(negedge clk);
    chk("t6_incnt", 32'(tok_in_cnt), 32'd1);
    chk("t6_outcnt", 32'(tok_out_cnt), 32'd1);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_expq", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
